// File: rtl/fpu_op_sequencer_if.sv
// rtl/fpu_op_sequencer_if.sv - request, unit and response signals of the FP op sequencer
interface fpu_op_sequencer_if #(
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic [7:0]       unit_sel;
  logic             unit_start;
  logic [31:0]      unit_a;
  logic [31:0]      unit_b;
  logic [31:0]      unit_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output flush, in_valid, in_op, in_rs1, in_rs2, in_tag, unit_result, out_ready,
    input  in_ready, unit_sel, unit_start, unit_a, unit_b, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_rs1, in_rs2, in_tag, unit_result, out_ready,
    output in_ready, unit_sel, unit_start, unit_a, unit_b, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - single-issue sequencer for fixed-latency FP units
// Despite its name, resetn is an asynchronous active-high reset.
module fpu_op_sequencer #(
  parameter int TAG_W    = 5,
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 16,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CVT  = 1
) (
  input logic clk,
  input logic resetn,
  fpu_op_sequencer_if.slave bus
);

  localparam int MAX_A   = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int MAX_B   = (LAT_DIV > LAT_SQRT) ? LAT_DIV : LAT_SQRT;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_LAT = (MAX_AB > LAT_CVT) ? MAX_AB : LAT_CVT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept;

  function automatic logic [CNT_W-1:0] lat_m1(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return CNT_W'(LAT_ADD - 1);
      3'd2:       return CNT_W'(LAT_MUL - 1);
      3'd3:       return CNT_W'(LAT_DIV - 1);
      3'd4:       return CNT_W'(LAT_SQRT - 1);
      default:    return CNT_W'(LAT_CVT - 1);
    endcase
  endfunction

  assign accept = (state == IDLE) && bus.in_valid && !bus.flush;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    if (cnt == '0) next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // flush outranks both the request and the response handshake
    if (bus.flush) next_state = IDLE;
  end

  always_comb begin
    bus.in_ready  = (state == IDLE) && !resetn;
    bus.unit_sel  = (state == EXEC) ? (8'b1 << op_q) : 8'b0;
    bus.out_valid = (state == DONE);
    bus.busy      = (state == EXEC) || (state == DONE);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt            <= '0;
      op_q           <= '0;
      tag_q          <= '0;
      bus.unit_a     <= '0;
      bus.unit_b     <= '0;
      bus.unit_start <= 1'b0;
      bus.out_data   <= '0;
      bus.out_tag    <= '0;
    end else begin
      bus.unit_start <= accept;
      if (accept) begin
        op_q       <= bus.in_op;
        tag_q      <= bus.in_tag;
        bus.unit_a <= bus.in_rs1;
        bus.unit_b <= bus.in_rs2;
        cnt        <= lat_m1(bus.in_op);
      end
      if (state == EXEC && !bus.flush) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          bus.out_data <= bus.unit_result;
          bus.out_tag  <= tag_q;
        end
      end
      if (bus.flush) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb/tb_fpu_op_sequencer.sv - directed self-checking bench for fpu_op_sequencer
module tb_fpu_op_sequencer;

  logic clk = 1'b0;
  logic resetn;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fpu_op_sequencer_if #(.TAG_W(5)) bus ();

  fpu_op_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] tag, input logic [31:0] res);
    bus.in_op       = op;
    bus.in_rs1      = a;
    bus.in_rs2      = b;
    bus.in_tag      = tag;
    bus.unit_result = res;
    bus.in_valid    = 1'b1;
  endtask

  initial begin
    int  n;
    logic ok;

    resetn          = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_op       = '0;
    bus.in_rs1      = '0;
    bus.in_rs2      = '0;
    bus.in_tag      = '0;
    bus.unit_result = '0;
    bus.out_ready   = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_unit_sel", {24'b0, bus.unit_sel}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    resetn = 1'b0;
    tick();
    chk("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // FCVT_W_S, latency 1
    req(3'd5, 32'h4040_0000, 32'h0, 5'd7, 32'h0000_0003);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("cvt_start", {31'b0, bus.unit_start}, 32'd1);
    chk("cvt_sel", {24'b0, bus.unit_sel}, 32'h20);
    chk("cvt_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("cvt_valid_early", {31'b0, bus.out_valid}, 32'd0);
    tick();
    chk("cvt_start_off", {31'b0, bus.unit_start}, 32'd0);
    chk("cvt_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("cvt_data", bus.out_data, 32'h3);
    chk("cvt_tag", {27'b0, bus.out_tag}, 32'd7);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("cvt_hs_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("cvt_hs_busy", {31'b0, bus.busy}, 32'd0);

    // FDIV, 16 EXEC cycles with stable operands
    req(3'd3, 32'h4120_0000, 32'h4000_0000, 5'd3, 32'h40A0_0000);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    ok = 1'b1;
    while (!bus.out_valid && n < 40) begin
      if (bus.unit_a !== 32'h4120_0000 || bus.unit_b !== 32'h4000_0000 || bus.unit_sel !== 8'h08)
        ok = 1'b0;
      n++;
      tick();
    end
    chk("div_exec_cycles", n, 32'd16);
    chk("div_operands_stable", {31'b0, ok}, 32'd1);
    chk("div_data", bus.out_data, 32'h40A0_0000);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // FMUL with 5 cycles of backpressure, a second request waiting
    req(3'd2, 32'h3FC0_0000, 32'h4000_0000, 5'd9, 32'h4040_0000);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("mul_valid_early", {31'b0, bus.out_valid}, 32'd0);
    tick();
    chk("mul_valid", {31'b0, bus.out_valid}, 32'd1);
    req(3'd0, 32'h1, 32'h2, 5'd2, 32'h1111_1111);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h4040_0000 ||
          bus.out_tag !== 5'd9 || bus.in_ready !== 1'b0)
        ok = 1'b0;
      tick();
    end
    chk("mul_hold_stable", {31'b0, ok}, 32'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("mul_in_ready_hs", {31'b0, bus.in_ready}, 32'd0);
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("mul_after_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mul_after_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("mul_after_busy", {31'b0, bus.busy}, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("add2_start", {31'b0, bus.unit_start}, 32'd1);
    chk("add2_sel", {24'b0, bus.unit_sel}, 32'h01);
    tick(); tick();
    chk("add2_valid_early", {31'b0, bus.out_valid}, 32'd0);
    tick();
    chk("add2_data", bus.out_data, 32'h1111_1111);
    chk("add2_tag", {27'b0, bus.out_tag}, 32'd2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // flush in the second EXEC cycle of FADD, then a clean FSUB
    req(3'd0, 32'h5, 32'h6, 5'd1, 32'hDEAD_BEEF);
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_exec_busy", {31'b0, bus.busy}, 32'd0);
    chk("flush_exec_in_ready", {31'b0, bus.in_ready}, 32'd1);
    ok = 1'b1;
    repeat (4) begin
      if (bus.out_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("flush_no_result", {31'b0, ok}, 32'd1);
    req(3'd1, 32'h7, 32'h8, 5'd4, 32'h2222_2222);
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    chk("sub_valid_early", {31'b0, bus.out_valid}, 32'd0);
    tick();
    chk("sub_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("sub_data", bus.out_data, 32'h2222_2222);
    chk("sub_tag", {27'b0, bus.out_tag}, 32'd4);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // flush with in_valid in IDLE, then flush with out_ready in DONE
    req(3'd2, 32'h9, 32'hA, 5'd5, 32'h0);
    bus.flush = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    chk("flush_idle_busy", {31'b0, bus.busy}, 32'd0);
    req(3'd6, 32'h33, 32'h0, 5'd6, 32'h0000_0033);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("s_w_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("flush_done_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_done_busy", {31'b0, bus.busy}, 32'd0);

    // asynchronous reset in the middle of FSQRT
    req(3'd4, 32'h4080_0000, 32'h0, 5'd11, 32'h4000_0000);
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    chk("sqrt_busy", {31'b0, bus.busy}, 32'd1);
    chk("sqrt_sel", {24'b0, bus.unit_sel}, 32'h10);
    resetn = 1'b1;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_sel", {24'b0, bus.unit_sel}, 32'd0);
    chk("arst_unit_a", bus.unit_a, 32'd0);
    chk("arst_out_data", bus.out_data, 32'd0);
    chk("arst_out_tag", {27'b0, bus.out_tag}, 32'd0);
    chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    resetn = 1'b0;
    #1;
    chk("arst_rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    chk("arst_rel_valid", {31'b0, bus.out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
